cr_tlvp_rsm_nch: RTL and testbench

Multi-channel TLV reassembly stage, generalised to N_CH user channels. It merges N_CH user-inserted TLV streams and one passthrough TLV stream into a single outbound word stream. Each TLV frame is kept atomic: no interleaving of words between frames. Sits in the same slot as the existing single-user-channel reassembler, between the TLV parser passthrough path and the engine output AXI4-S adapter.

---
 rtl/cr_tlvp_rsm_nch.sv | 136 +++++++++++++
 tb/tb_cr_tlvp_rsm_nch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cr_tlvp_rsm_nch.sv
// cr_tlvp_rsm_nch: merges N_CH user TLV FIFOs and a passthrough TLV stream into one frame-atomic output FIFO (pt_ob_* in, usr_ob_* in/status, tlvp_ob_* out)
module cr_tlvp_rsm_nch #(
  parameter int N_CH = 4,
  parameter int DATA_W = 64,
  parameter int UF_DEPTH = 16,
  parameter int UF_AFULL_VAL = 1,
  parameter int OF_DEPTH = 16,
  parameter int OF_AEMPTY_VAL = 1,
  parameter int PT_PRIO = 0,
  parameter int SRC_W = $clog2(N_CH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pt_ob_empty,
  input  logic [DATA_W-1:0]        pt_ob_data,
  input  logic                     pt_ob_eot,
  output logic                     pt_ob_rd,
  input  logic [N_CH-1:0]          usr_ob_wr,
  input  logic [N_CH*DATA_W-1:0]   usr_ob_data,
  input  logic [N_CH-1:0]          usr_ob_eot,
  output logic [N_CH-1:0]          usr_ob_full,
  output logic [N_CH-1:0]          usr_ob_afull,
  output logic [N_CH-1:0]          usr_ob_ovfl_err,
  input  logic                     tlvp_ob_rd,
  output logic                     tlvp_ob_empty,
  output logic                     tlvp_ob_aempty,
  output logic [DATA_W-1:0]        tlvp_ob_data,
  output logic                     tlvp_ob_last,
  output logic [SRC_W-1:0]         tlvp_ob_src
);
  localparam int UA = $clog2(UF_DEPTH);
  localparam int OA = $clog2(OF_DEPTH);
  localparam logic [SRC_W-1:0] PT_ID = SRC_W'(N_CH);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [SRC_W-1:0] grant, rr, sel;
  logic [N_CH:0] req;
  logic [N_CH-1:0] u_empty, u_eot, u_full, u_afull, u_err;
  logic [DATA_W-1:0] u_data [N_CH];
  logic src_empty, src_eot, xfer, of_rd, of_empty;
  logic [DATA_W-1:0] src_data;
  logic [SRC_W+DATA_W:0] of_mem [OF_DEPTH];
  logic [SRC_W+DATA_W:0] of_head;
  logic [OA-1:0] of_wp, of_rp;
  logic [OA:0] of_cnt;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DATA_W:0] mem [UF_DEPTH];
    logic [UA-1:0] wp, rp;
    logic [UA:0] cnt, cnt_n;
    logic wr_ok, pop, full_q, afull_q, err_q;
    assign wr_ok = usr_ob_wr[c] & ~full_q;
    assign pop = xfer && grant == SRC_W'(c);
    assign cnt_n = cnt + (UA+1)'(wr_ok) - (UA+1)'(pop);
    always_ff @(posedge clk)
      if (rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        full_q <= 1'b0;
        afull_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        if (wr_ok) begin
          mem[wp] <= {usr_ob_eot[c], usr_ob_data[c*DATA_W +: DATA_W]};
          wp <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt_n;
        full_q <= cnt_n == (UA+1)'(UF_DEPTH);
        afull_q <= (UA+1)'(UF_DEPTH) - cnt_n <= (UA+1)'(UF_AFULL_VAL);
        err_q <= err_q | (usr_ob_wr[c] & full_q);
      end
    assign u_empty[c] = cnt == '0;
    assign u_eot[c] = mem[rp][DATA_W];
    assign u_data[c] = mem[rp][DATA_W-1:0];
    assign u_full[c] = full_q;
    assign u_afull[c] = afull_q;
    assign u_err[c] = err_q;
  end
  always_comb begin
    req = {~pt_ob_empty, ~u_empty};
    sel = rr;
    for (int k = N_CH; k >= 0; k--)
      if (req[SRC_W'((int'(rr) + k) % (N_CH + 1))]) sel = SRC_W'((int'(rr) + k) % (N_CH + 1));
    if (PT_PRIO != 0 && req[N_CH]) sel = PT_ID;
  end
  always_comb begin
    src_empty = pt_ob_empty;
    src_eot = pt_ob_eot;
    src_data = pt_ob_data;
    for (int i = 0; i < N_CH; i++)
      if (grant == SRC_W'(i)) begin
        src_empty = u_empty[i];
        src_eot = u_eot[i];
        src_data = u_data[i];
      end
  end
  assign xfer = !rst && state == XFER && !src_empty && of_cnt != (OA+1)'(OF_DEPTH);
  assign pt_ob_rd = xfer && grant == PT_ID;
  assign of_rd = tlvp_ob_rd && of_cnt != '0;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        grant <= sel;
        state <= XFER;
      end
    end else if (xfer && src_eot) begin
      state <= IDLE;
      rr <= grant == PT_ID ? '0 : grant + 1'b1;
    end
  always_ff @(posedge clk)
    if (rst) begin
      of_wp <= '0;
      of_rp <= '0;
      of_cnt <= '0;
    end else begin
      if (xfer) begin
        of_mem[of_wp] <= {grant, src_eot, src_data};
        of_wp <= of_wp + 1'b1;
      end
      if (of_rd) of_rp <= of_rp + 1'b1;
      of_cnt <= of_cnt + (OA+1)'(xfer) - (OA+1)'(of_rd);
    end
  assign of_empty = rst || of_cnt == '0;
  assign of_head = of_empty ? '0 : of_mem[of_rp];
  assign {tlvp_ob_src, tlvp_ob_last, tlvp_ob_data} = of_head;
  assign tlvp_ob_empty = of_empty;
  assign tlvp_ob_aempty = rst || of_cnt <= (OA+1)'(OF_AEMPTY_VAL);
  assign usr_ob_full = rst ? '0 : u_full;
  assign usr_ob_afull = rst ? '0 : u_afull;
  assign usr_ob_ovfl_err = rst ? '0 : u_err;
endmodule

// File: tb/tb_cr_tlvp_rsm_nch.sv
// tb_cr_tlvp_rsm_nch: scoreboard bench for cr_tlvp_rsm_nch (round-robin instance plus a passthrough-priority instance)
module tb_cr_tlvp_rsm_nch;
  localparam int N = 4;
  localparam int W = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic pt_ob_empty, pt_ob_eot, pt_ob_rd, tlvp_ob_rd, tlvp_ob_empty, tlvp_ob_aempty, tlvp_ob_last;
  logic [W-1:0] pt_ob_data, tlvp_ob_data;
  logic [N-1:0] usr_ob_wr, usr_ob_eot, usr_ob_full, usr_ob_afull, usr_ob_ovfl_err;
  logic [N*W-1:0] usr_ob_data;
  logic [2:0] tlvp_ob_src;
  logic p_pt_empty, p_pt_eot, p_pt_rd, p_empty, p_aempty, p_last;
  logic p_rd = 1'b1;
  logic [W-1:0] p_pt_data, p_data;
  logic [N-1:0] p_wr, p_eot, p_full, p_afull, p_err;
  logic [N*W-1:0] p_udata;
  logic [2:0] p_src;
  logic [W:0] pt_q[$], p_q[$];
  logic [W+3:0] exp_q[$], p_log[$], p_exp[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic pt_pop, p_pop;
  cr_tlvp_rsm_nch #(.N_CH(N), .DATA_W(W), .PT_PRIO(0)) u_dut (
    .clk(clk), .rst(rst),
    .pt_ob_empty(pt_ob_empty), .pt_ob_data(pt_ob_data), .pt_ob_eot(pt_ob_eot), .pt_ob_rd(pt_ob_rd),
    .usr_ob_wr(usr_ob_wr), .usr_ob_data(usr_ob_data), .usr_ob_eot(usr_ob_eot),
    .usr_ob_full(usr_ob_full), .usr_ob_afull(usr_ob_afull), .usr_ob_ovfl_err(usr_ob_ovfl_err),
    .tlvp_ob_rd(tlvp_ob_rd), .tlvp_ob_empty(tlvp_ob_empty), .tlvp_ob_aempty(tlvp_ob_aempty),
    .tlvp_ob_data(tlvp_ob_data), .tlvp_ob_last(tlvp_ob_last), .tlvp_ob_src(tlvp_ob_src)
  );
  cr_tlvp_rsm_nch #(.N_CH(N), .DATA_W(W), .PT_PRIO(1)) u_dut_prio (
    .clk(clk), .rst(rst),
    .pt_ob_empty(p_pt_empty), .pt_ob_data(p_pt_data), .pt_ob_eot(p_pt_eot), .pt_ob_rd(p_pt_rd),
    .usr_ob_wr(p_wr), .usr_ob_data(p_udata), .usr_ob_eot(p_eot),
    .usr_ob_full(p_full), .usr_ob_afull(p_afull), .usr_ob_ovfl_err(p_err),
    .tlvp_ob_rd(p_rd), .tlvp_ob_empty(p_empty), .tlvp_ob_aempty(p_aempty),
    .tlvp_ob_data(p_data), .tlvp_ob_last(p_last), .tlvp_ob_src(p_src)
  );
  task automatic chk(string nm, logic [W+3:0] act, logic [W+3:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask
  task automatic refresh;
    pt_ob_empty = pt_q.size() == 0;
    {pt_ob_eot, pt_ob_data} = pt_q.size() > 0 ? pt_q[0] : '0;
    p_pt_empty = p_q.size() == 0;
    {p_pt_eot, p_pt_data} = p_q.size() > 0 ? p_q[0] : '0;
  endtask
  task automatic tick;
    @(negedge clk);
    pt_pop = pt_ob_rd;
    p_pop = p_pt_rd;
    @(posedge clk);
    #1;
    if (pt_pop && pt_q.size() > 0) void'(pt_q.pop_front());
    if (p_pop && p_q.size() > 0) void'(p_q.pop_front());
    usr_ob_wr = '0;
    p_wr = '0;
    refresh();
    cyc++;
  endtask
  task automatic uw(int c, logic e, logic [W-1:0] d);
    usr_ob_wr[c] = 1'b1;
    usr_ob_eot[c] = e;
    usr_ob_data[c*W +: W] = d;
  endtask
  task automatic pw(int c, logic e, logic [W-1:0] d);
    p_wr[c] = 1'b1;
    p_eot[c] = e;
    p_udata[c*W +: W] = d;
  endtask
  task automatic ex(int s, logic l, logic [W-1:0] d);
    exp_q.push_back({3'(s), l, d});
  endtask
  task automatic drain(string nm, int bound);
    int n = 0;
    tlvp_ob_rd = 1'b1;
    while (!(tlvp_ob_empty && exp_q.size() == 0) && n < bound) begin
      tick();
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (tlvp_ob_empty) chk("empty_head_zero", {tlvp_ob_src, tlvp_ob_last, tlvp_ob_data}, '0);
      else if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: actual=%0h required=none", {tlvp_ob_src, tlvp_ob_last, tlvp_ob_data});
      end else begin
        chk("out_word", {tlvp_ob_src, tlvp_ob_last, tlvp_ob_data}, exp_q[0]);
        if (tlvp_ob_rd) void'(exp_q.pop_front());
      end
    end
  always @(negedge clk)
    if (!rst && !p_empty) p_log.push_back({p_src, p_last, p_data});
  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end
  initial begin
    usr_ob_wr = '0;
    usr_ob_eot = '0;
    usr_ob_data = '0;
    p_wr = '0;
    p_eot = '0;
    p_udata = '0;
    tlvp_ob_rd = 1'b0;
    refresh();
    repeat (3) tick();
    chk("rst_pt_rd", pt_ob_rd, 0);
    chk("rst_empty", tlvp_ob_empty, 1);
    rst = 1'b0;
    #1;
    chk("post_rst_empty", tlvp_ob_empty, 1);
    chk("post_rst_aempty", tlvp_ob_aempty, 1);
    chk("post_rst_flags", {usr_ob_full, usr_ob_afull, usr_ob_ovfl_err}, 0);
    chk("post_rst_head", {tlvp_ob_src, tlvp_ob_last, tlvp_ob_data}, 0);
    cyc = 0;
    tlvp_ob_rd = 1'b1;
    for (int c = 0; c < N; c++)
      for (int w = 0; w < 3; w++) ex(c, w == 2, 64'h1000 + c * 16 + w);
    for (int w = 0; w < 3; w++) ex(4, w == 2, 64'h2000 + w);
    for (int i = 0; i < 6; i++) p_q.push_back({i % 2 == 1, 64'h8000 + i});
    for (int i = 0; i < 6; i++) p_exp.push_back({3'd4, i % 2 == 1, 64'h8000 + i});
    p_exp.push_back({3'd2, 1'b0, 64'hA0});
    p_exp.push_back({3'd2, 1'b1, 64'hA1});
    p_exp.push_back({3'd2, 1'b1, 64'hB0});
    for (int w = 0; w < 3; w++) begin
      for (int c = 0; c < N; c++) uw(c, w == 2, 64'h1000 + c * 16 + w);
      pt_q.push_back({w == 2, 64'h2000 + w});
      pw(2, w != 0, w == 2 ? 64'hB0 : 64'hA0 + w);
      tick();
    end
    while (!(tlvp_ob_empty && exp_q.size() == 0) && cyc < 100) tick();
    chk("rr_drain_cycle", cyc, 22);
    chk("prio_count", p_log.size(), 9);
    for (int i = 0; i < 9 && i < p_log.size(); i++) chk($sformatf("prio_word%0d", i), p_log[i], p_exp[i]);
    tlvp_ob_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pt_q.push_back({i == 19, 64'h3000 + i});
      ex(4, i == 19, 64'h3000 + i);
    end
    for (int i = 0; i < 16; i++) ex(1, i == 15, 64'h4000 + i);
    repeat (25) tick();
    chk("stall_pt_left", pt_q.size(), 4);
    chk("stall_pt_rd", pt_ob_rd, 0);
    chk("stall_aempty", tlvp_ob_aempty, 0);
    for (int i = 0; i < 17; i++) begin
      uw(1, i == 15, i == 16 ? 64'hDEAD : 64'h4000 + i);
      tick();
      if (i == 13) chk("afull_at14", usr_ob_afull[1], 0);
      if (i == 14) chk("afull_at15", {usr_ob_afull[1], usr_ob_full[1]}, 2'b10);
      if (i == 15) chk("full_at16", {usr_ob_full[1], usr_ob_ovfl_err[1]}, 2'b10);
      if (i == 16) chk("ovfl_at17", usr_ob_ovfl_err, 4'b0010);
    end
    repeat (3) tick();
    chk("ovfl_sticky", usr_ob_ovfl_err, 4'b0010);
    chk("full_held", usr_ob_full, 4'b0010);
    drain("stall_drain_left", 200);
    chk("full_cleared", usr_ob_full, 0);
    tlvp_ob_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex(0, 1'b0, 64'h5000 + i);
      uw(0, 1'b0, 64'h5000 + i);
      tick();
    end
    chk("pre_rst_nonempty", tlvp_ob_empty, 0);
    chk("pre_rst_err", usr_ob_ovfl_err, 4'b0010);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("in_rst_outputs", {tlvp_ob_empty, tlvp_ob_aempty, pt_ob_rd, usr_ob_full, usr_ob_ovfl_err}, 11'b11000000000);
    chk("in_rst_head", {tlvp_ob_src, tlvp_ob_last, tlvp_ob_data}, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_empty", tlvp_ob_empty, 1);
    chk("after_rst_full", usr_ob_full, 0);
    chk("after_rst_err", usr_ob_ovfl_err, 0);
    for (int i = 0; i < 3; i++) begin
      ex(0, i == 2, 64'h6000 + i);
      uw(0, i == 2, 64'h6000 + i);
      tick();
    end
    drain("rst_frame_left", 50);
    tlvp_ob_rd = 1'b1;
    repeat (3) begin
      tick();
      chk("rd_on_empty", {tlvp_ob_empty, tlvp_ob_aempty}, 2'b11);
    end
    tlvp_ob_rd = 1'b0;
    ex(2, 1'b1, 64'h7777);
    uw(2, 1'b1, 64'h7777);
    tick();
    chk("lat_c1_empty", tlvp_ob_empty, 1);
    tick();
    chk("lat_c2_empty", tlvp_ob_empty, 1);
    tick();
    chk("lat_c3_empty", tlvp_ob_empty, 0);
    chk("lat_c3_word", {tlvp_ob_src, tlvp_ob_last, tlvp_ob_data}, {3'd2, 1'b1, 64'h7777});
    tlvp_ob_rd = 1'b1;
    tick();
    tlvp_ob_rd = 1'b0;
    tick();
    chk("final_empty", tlvp_ob_empty, 1);
    chk("final_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
